// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Initiator side of the data-RAM interface. Turns CPU load/store requests
//   (byte, half, word; signed or unsigned loads) into registered, active-low
//   _RD/_WR strobes on a big-endian, word-wide, level-sensitive RAM.
//   Sub-word stores are done as read-modify-write of the containing word.
//
// Ports
//   CLK, Reset          clock (rising edge), synchronous active-high reset
//   req_valid/req_ready request handshake; req_ready is high only in IDLE
//   req_we, req_size,   store/load, size (00 byte, 01 half, 10 word, 11 illegal),
//   req_signed          load sign extension
//   req_addr, req_wdata byte address, right-justified store data
//   resp_valid          one-cycle completion pulse
//   resp_err, resp_rdata qualified by resp_valid, zero otherwise
//   _RD, _WR            RAM strobes, active low, never low together
//   DAddr, MemWData     word-aligned RAM address and write data
//   MemRData            combinational RAM read data
//   state_dbg           current FSM state (debug visibility)
//
// Handshake: a request transfers on the rising edge where req_valid and
// req_ready are both high; all req_* fields are sampled only on that edge and
// no further request is taken until the response cycle has passed.
module mem_access_ctrl #(
   parameter int ADDR_LIMIT = 60,
   parameter int RD_WAIT    = 1,
   parameter int WR_PULSE   = 1
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic        _RD,
   output logic        _WR,
   output logic [31:0] DAddr,
   output logic [31:0] MemWData,
   input  logic [31:0] MemRData,
   output logic [2:0]  state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RD    = 3'd1,
      S_SETUP = 3'd2,
      S_WR    = 3'd3,
      S_HOLD  = 3'd4,
      S_RESP  = 3'd5
   } state_t;

   localparam logic [3:0] RD_LAST = 4'(RD_WAIT - 1);
   localparam logic [3:0] WR_LAST = 4'(WR_PULSE - 1);

   state_t      state;
   logic [3:0]  cnt;
   logic        op_we;
   logic [1:0]  op_size;
   logic        op_signed;
   logic [1:0]  op_off;
   logic [31:0] op_wdata;

   assign state_dbg = state;

   // Acceptance checks. The range sum is done in 33 bits so addresses near
   // the top of the 32-bit space cannot wrap into the legal window.
   logic [32:0] word_end;
   logic        acc_err;

   always_comb begin
      word_end = {1'b0, req_addr[31:2], 2'b00} + 33'd4;
      acc_err  = (req_size == 2'b11)
              || (req_size == 2'b01 && req_addr[0])
              || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
              || (word_end > 33'(ADDR_LIMIT));
   end

   // Big-endian lane select: offset 0 is the most significant byte.
   function automatic logic [31:0] load_extract(input logic [31:0] w,
                                                input logic [1:0]  sz,
                                                input logic [1:0]  off,
                                                input logic        sgn);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      h = off[1] ? w[15:0] : w[31:16];
      case (sz)
         2'b00:   r = sgn ? {{24{b[7]}}, b} : {24'h0, b};
         2'b01:   r = sgn ? {{16{h[15]}}, h} : {16'h0, h};
         default: r = w;
      endcase
      return r;
   endfunction

   // Replace only the addressed lane(s) of the captured word.
   function automatic logic [31:0] store_merge(input logic [31:0] w,
                                               input logic [1:0]  sz,
                                               input logic [1:0]  off,
                                               input logic [31:0] d);
      logic [31:0] r;
      r = w;
      if (sz == 2'b00) begin
         case (off)
            2'd0:    r[31:24] = d[7:0];
            2'd1:    r[23:16] = d[7:0];
            2'd2:    r[15:8]  = d[7:0];
            default: r[7:0]   = d[7:0];
         endcase
      end else if (off[1]) begin
         r[15:0] = d[15:0];
      end else begin
         r[31:16] = d[15:0];
      end
      return r;
   endfunction

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state      <= S_IDLE;
         req_ready  <= 1'b1;
         _RD        <= 1'b1;
         _WR        <= 1'b1;
         DAddr      <= 32'h0;
         MemWData   <= 32'h0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'h0;
         cnt        <= 4'h0;
         op_we      <= 1'b0;
         op_size    <= 2'b00;
         op_signed  <= 1'b0;
         op_off     <= 2'b00;
         op_wdata   <= 32'h0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  op_we     <= req_we;
                  op_size   <= req_size;
                  op_signed <= req_signed;
                  op_off    <= req_addr[1:0];
                  op_wdata  <= req_wdata;
                  if (acc_err) begin
                     // Rejected: straight to the response, RAM untouched.
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     state      <= S_RESP;
                  end else begin
                     DAddr <= {req_addr[31:2], 2'b00};
                     if (req_we && req_size == 2'b10) begin
                        MemWData <= req_wdata;
                        state    <= S_SETUP;
                     end else begin
                        // Loads and sub-word stores both start with a read.
                        _RD   <= 1'b0;
                        cnt   <= RD_LAST;
                        state <= S_RD;
                     end
                  end
               end
            end
            S_RD: begin
               if (cnt == 4'h0) begin
                  _RD <= 1'b1;
                  if (op_we) begin
                     MemWData <= store_merge(MemRData, op_size, op_off, op_wdata);
                     state    <= S_SETUP;
                  end else begin
                     resp_rdata <= load_extract(MemRData, op_size, op_off, op_signed);
                     resp_valid <= 1'b1;
                     state      <= S_RESP;
                  end
               end else begin
                  cnt <= cnt - 4'h1;
               end
            end
            S_SETUP: begin
               _WR   <= 1'b0;
               cnt   <= WR_LAST;
               state <= S_WR;
            end
            S_WR: begin
               if (cnt == 4'h0) begin
                  _WR   <= 1'b1;
                  state <= S_HOLD;
               end else begin
                  cnt <= cnt - 4'h1;
               end
            end
            S_HOLD: begin
               resp_valid <= 1'b1;
               state      <= S_RESP;
            end
            S_RESP: begin
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               resp_rdata <= 32'h0;
               req_ready  <= 1'b1;
               state      <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a word-wide RAM model, a request driver, and a
// monitor that pops expected responses {err, rdata, due cycle} from exp_q.
module tb_mem_access_ctrl;

   localparam int ADDR_LIMIT = 60;
   localparam int RD_WAIT    = 1;
   localparam int WR_PULSE   = 3;
   localparam int LAT_LD     = RD_WAIT + 1;
   localparam int LAT_SW     = WR_PULSE + 3;
   localparam int LAT_SUB    = RD_WAIT + WR_PULSE + 3;
   localparam int LAT_ERR    = 1;

   logic        CLK;
   logic        Reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic        _RD;
   logic        _WR;
   logic [31:0] DAddr;
   logic [31:0] MemWData;
   logic [31:0] MemRData;
   logic [2:0]  state_dbg;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int last_acc = 0;
   logic [64:0] exp_q[$];

   logic [31:0] ram [0:15] = '{default: 32'h0};

   mem_access_ctrl #(
      .ADDR_LIMIT(ADDR_LIMIT),
      .RD_WAIT   (RD_WAIT),
      .WR_PULSE  (WR_PULSE)
   ) dut (
      .CLK       (CLK),
      .Reset     (Reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_size  (req_size),
      .req_signed(req_signed),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .resp_valid(resp_valid),
      .resp_err  (resp_err),
      .resp_rdata(resp_rdata),
      ._RD       (_RD),
      ._WR       (_WR),
      .DAddr     (DAddr),
      .MemWData  (MemWData),
      .MemRData  (MemRData),
      .state_dbg (state_dbg)
   );

   // Clock / reset block
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // Level-sensitive RAM: written on every edge that sees _WR low.
   always @(posedge CLK) if (!_WR) ram[DAddr[5:2]] <= MemWData;
   assign MemRData = ram[DAddr[5:2]];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
      end
   endtask

   // Monitor / scoreboard
   int          wr_run = 0;
   logic [31:0] wr_addr, wr_data;
   logic [64:0] e;
   always @(negedge CLK) begin
      if (Reset) begin
         wr_run = 0;
      end else begin
         chk("strobe_overlap", 32'(!_RD && !_WR), 32'd0);
         if (!_WR) begin
            if (wr_run == 0) begin
               wr_addr = DAddr;
               wr_data = MemWData;
            end else begin
               chk("wr_addr_stable", DAddr, wr_addr);
               chk("wr_data_stable", MemWData, wr_data);
            end
            wr_run++;
         end else if (wr_run != 0) begin
            chk("wr_pulse_len", 32'(wr_run), 32'(WR_PULSE));
            wr_run = 0;
         end
         if (resp_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_resp actual=resp_valid required=none rdata=0x%08h", resp_rdata);
            end else begin
               e = exp_q.pop_front();
               chk("resp_err", 32'(resp_err), 32'(e[64]));
               chk("resp_rdata", resp_rdata, e[63:32]);
               chk("resp_latency", 32'(cyc), e[31:0]);
            end
         end else begin
            chk("quiet_rdata", resp_rdata, 32'h0);
            chk("quiet_err", 32'(resp_err), 32'd0);
         end
      end
   end

   // Driver tasks (called at a negedge, return at a negedge)
   task automatic do_req(input logic we, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic e_err, input logic [31:0] e_rd, input int lat);
      int n = 0;
      req_valid  = 1'b1;
      req_we     = we;
      req_size   = sz;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wd;
      while (!req_ready && n < 100) begin
         @(negedge CLK);
         n++;
      end
      if (!req_ready) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout actual=not_accepted required=accepted addr=0x%08h", addr);
         req_valid = 1'b0;
      end else begin
         exp_q.push_back({e_err, e_rd, 32'(cyc + lat)});
         last_acc = cyc;
         @(negedge CLK);
         chk("ready_busy", 32'(req_ready), 32'd0);
      end
   endtask

   task automatic drain(input bit no_strobe);
      int n = 0;
      req_valid = 1'b0;
      while ((exp_q.size() != 0 || !req_ready) && n < 100) begin
         if (no_strobe) begin
            chk("err_no_rd", 32'(_RD), 32'd1);
            chk("err_no_wr", 32'(_WR), 32'd1);
         end
         @(negedge CLK);
         n++;
      end
      if (n >= 100) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout actual=pending%0d required=pending0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic txn(input logic we, input logic [1:0] sz, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic e_err, input logic [31:0] e_rd, input int lat,
                      input bit no_strobe);
      do_req(we, sz, sgn, addr, wd, e_err, e_rd, lat);
      drain(no_strobe);
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      int a0;
      int n;
      Reset      = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_size   = 2'b00;
      req_signed = 1'b0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      repeat (3) @(negedge CLK);
      chk("rst_rd", 32'(_RD), 32'd1);
      chk("rst_wr", 32'(_WR), 32'd1);
      chk("rst_daddr", DAddr, 32'h0);
      chk("rst_wdata", MemWData, 32'h0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_rdata", resp_rdata, 32'h0);
      Reset = 1'b0;
      @(negedge CLK);
      chk("rst_ready", 32'(req_ready), 32'd1);

      // 1: word store then word load
      txn(1'b1, 2'b10, 1'b0, 32'd8, 32'h11223344, 1'b0, 32'h0, LAT_SW, 1'b0);
      chk("sw8_ram", ram[2], 32'h11223344);
      txn(1'b0, 2'b10, 1'b0, 32'd8, 32'h0, 1'b0, 32'h11223344, LAT_LD, 1'b0);
      txn(1'b0, 2'b00, 1'b0, 32'd8, 32'h0, 1'b0, 32'h00000011, LAT_LD, 1'b0);
      txn(1'b0, 2'b00, 1'b0, 32'd11, 32'h0, 1'b0, 32'h00000044, LAT_LD, 1'b0);

      // 2: extraction and extension
      txn(1'b1, 2'b10, 1'b0, 32'd12, 32'h80FF7F01, 1'b0, 32'h0, LAT_SW, 1'b0);
      txn(1'b0, 2'b00, 1'b1, 32'd13, 32'h0, 1'b0, 32'hFFFFFFFF, LAT_LD, 1'b0);
      txn(1'b0, 2'b00, 1'b0, 32'd12, 32'h0, 1'b0, 32'h00000080, LAT_LD, 1'b0);
      txn(1'b0, 2'b01, 1'b1, 32'd14, 32'h0, 1'b0, 32'h00007F01, LAT_LD, 1'b0);
      txn(1'b0, 2'b01, 1'b1, 32'd12, 32'h0, 1'b0, 32'hFFFF80FF, LAT_LD, 1'b0);
      txn(1'b0, 2'b01, 1'b0, 32'd12, 32'h0, 1'b0, 32'h000080FF, LAT_LD, 1'b0);
      txn(1'b0, 2'b00, 1'b1, 32'd15, 32'h0, 1'b0, 32'h00000001, LAT_LD, 1'b0);
      txn(1'b0, 2'b10, 1'b1, 32'd12, 32'h0, 1'b0, 32'h80FF7F01, LAT_LD, 1'b0);

      // 3: read-modify-write stores (upper wdata bits must be ignored)
      txn(1'b1, 2'b10, 1'b0, 32'd16, 32'hAABBCCDD, 1'b0, 32'h0, LAT_SW, 1'b0);
      txn(1'b1, 2'b00, 1'b0, 32'd18, 32'hFFFFFF5A, 1'b0, 32'h0, LAT_SUB, 1'b0);
      chk("sb18_ram", ram[4], 32'hAABB5ADD);
      txn(1'b1, 2'b01, 1'b0, 32'd16, 32'hABCD1234, 1'b0, 32'h0, LAT_SUB, 1'b0);
      chk("sh16_ram", ram[4], 32'h12345ADD);
      txn(1'b1, 2'b00, 1'b0, 32'd35, 32'h000000C3, 1'b0, 32'h0, LAT_SUB, 1'b0);
      chk("sb35_ram", ram[8], 32'h000000C3);

      // 4: rejected requests and the range boundary
      txn(1'b0, 2'b10, 1'b0, 32'd6, 32'h0, 1'b1, 32'h0, LAT_ERR, 1'b1);
      txn(1'b1, 2'b01, 1'b0, 32'd3, 32'hFFFF, 1'b1, 32'h0, LAT_ERR, 1'b1);
      chk("sh3_no_write", ram[0], 32'h0);
      txn(1'b0, 2'b10, 1'b0, 32'd60, 32'h0, 1'b1, 32'h0, LAT_ERR, 1'b1);
      txn(1'b0, 2'b11, 1'b0, 32'd0, 32'h0, 1'b1, 32'h0, LAT_ERR, 1'b1);
      txn(1'b1, 2'b00, 1'b0, 32'd61, 32'h55, 1'b1, 32'h0, LAT_ERR, 1'b1);
      txn(1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h0, 1'b1, 32'h0, LAT_ERR, 1'b1);
      txn(1'b1, 2'b10, 1'b0, 32'd56, 32'hCAFEF00D, 1'b0, 32'h0, LAT_SW, 1'b0);
      txn(1'b0, 2'b10, 1'b0, 32'd56, 32'h0, 1'b0, 32'hCAFEF00D, LAT_LD, 1'b0);
      txn(1'b0, 2'b00, 1'b1, 32'd59, 32'h0, 1'b0, 32'h0000000D, LAT_LD, 1'b0);

      // 6: requests queued back to back with req_valid held high
      do_req(1'b0, 2'b10, 1'b0, 32'd8, 32'h0, 1'b0, 32'h11223344, LAT_LD);
      a0 = last_acc;
      do_req(1'b0, 2'b00, 1'b0, 32'd17, 32'h0, 1'b0, 32'h00000034, LAT_LD);
      chk("queue_gap1", 32'(last_acc - a0), 32'(LAT_LD + 1));
      a0 = last_acc;
      do_req(1'b0, 2'b01, 1'b1, 32'd14, 32'h0, 1'b0, 32'h00007F01, LAT_LD);
      chk("queue_gap2", 32'(last_acc - a0), 32'(LAT_LD + 1));
      drain(1'b0);

      // 5: reset while _WR is low; the store gets no response
      do_req(1'b1, 2'b10, 1'b0, 32'd20, 32'hDEADBEEF, 1'b0, 32'h0, LAT_SW);
      req_valid = 1'b0;
      n = 0;
      while (_WR && n < 20) begin
         @(negedge CLK);
         n++;
      end
      chk("abort_saw_wr", 32'(_WR), 32'd0);
      Reset = 1'b1;
      @(negedge CLK);
      chk("abort_wr_high", 32'(_WR), 32'd1);
      chk("abort_rd_high", 32'(_RD), 32'd1);
      chk("abort_ready", 32'(req_ready), 32'd1);
      chk("abort_no_resp", 32'(resp_valid), 32'd0);
      @(negedge CLK);
      Reset = 1'b0;
      exp_q.delete();
      repeat (12) @(negedge CLK);
      chk("abort_ram_old_or_new", 32'(ram[5] == 32'h0 || ram[5] == 32'hDEADBEEF), 32'd1);
      txn(1'b0, 2'b10, 1'b0, 32'd20, 32'h0, 1'b0, 32'hDEADBEEF, LAT_LD, 1'b0);

      repeat (3) @(negedge CLK);
      chk("leftover_expected", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
